// File: rtl/bus_uart_tx_pkg.sv
// Shared constants, state type and frame builder for the bus UART transmitter.
// Defining BUS_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package bus_uart_tx_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;

   localparam int BUSY = 0;
   localparam int OVR  = 1;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 2;
`ifdef BUS_UART_TX_PARITY_EN
   localparam int PAR_BITS   = 1;
`else
   localparam int PAR_BITS   = 0;
`endif
   localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
   localparam int IDX_W      = $clog2(FRAME_BITS);

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } tx_state_e;

   typedef logic [FRAME_BITS-1:0] frame_t;

   // Bit 0 goes out first: start, data LSB first, [parity], stops.
   function automatic frame_t frame_build(
      input logic [DATA_BITS-1:0] d
   );
`ifdef BUS_UART_TX_PARITY_EN
      return {{STOP_BITS{1'b1}}, ^d, d, 1'b0};
`else
      return {{STOP_BITS{1'b1}}, d, 1'b0};
`endif
   endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// Asynchronous host bus seen by the UART transmitter.
// The host is the master; the transmitter is the slave.
interface bus_uart_tx_if;
   import bus_uart_tx_pkg::*;

   logic [1:0]           addr;
   logic                 rw;
   logic                 ncs;
   logic [DATA_BITS-1:0] wdata;
   logic [DATA_BITS-1:0] rdata;
   logic                 rdata_oe;

   modport master (
      output addr,
      output rw,
      output ncs,
      output wdata,
      input  rdata,
      input  rdata_oe
   );

   modport slave (
      input  addr,
      input  rw,
      input  ncs,
      input  wdata,
      output rdata,
      output rdata_oe
   );

endinterface

// File: rtl/bus_uart_tx_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input goes high.
// A level held high produces only the first pulse.
module edge_detect (
   input  logic clk,
   input  logic nrst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter: 8N2 frames (8E2 with BUS_UART_TX_PARITY_EN),
// data register at address 0, busy/overrun status at address 1.
module bus_uart_tx
   import bus_uart_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 139
) (
   input  logic         clk,
   input  logic         nrst,
   bus_uart_tx_if.slave bus,
   output logic         tx,
   output logic         busy,
   output logic         baud_tick
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'(BAUD_DIV - 1);

   logic [1:0]           ncs_q;
   logic [1:0]           rw_q;
   logic [1:0]           addr1_q;
   logic [1:0]           addr2_q;
   logic [DATA_BITS-1:0] wdata1_q;
   logic [DATA_BITS-1:0] wdata2_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ncs_q    <= 2'b11;
         rw_q     <= 2'b00;
         addr1_q  <= '0;
         addr2_q  <= '0;
         wdata1_q <= '0;
         wdata2_q <= '0;
      end else begin
         ncs_q    <= {ncs_q[0], bus.ncs};
         rw_q     <= {rw_q[0], bus.rw};
         addr1_q  <= bus.addr;
         addr2_q  <= addr1_q;
         wdata1_q <= bus.wdata;
         wdata2_q <= wdata1_q;
      end
   end

   logic wr_lvl;
   logic wr_pulse;

   assign wr_lvl = ~ncs_q[1] & ~rw_q[1];

   edge_detect u_wr_edge (
      .clk   (clk),
      .nrst  (nrst),
      .in    (wr_lvl),
      .pulse (wr_pulse)
   );

   tx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [IDX_W-1:0] idx_q;
   frame_t           frame_q;
   logic             tx_q;
   logic             ovr_q;
   logic             ovr_d;

   logic tick;
   logic last;
   logic wr_data;
   logic accept;
   logic set_ovr;
   logic clr_ovr;

   assign tick    = (cnt_q == CNT_MAX);
   assign last    = (idx_q == IDX_W'(FRAME_BITS - 1));
   assign wr_data = wr_pulse & (addr2_q == ADDR_DATA);

   // The edge closing the last stop bit may already take the next byte.
   assign accept  = wr_data &
                    ((state_q == ST_IDLE) | (tick & last));
   assign set_ovr = wr_data & ~accept;
   assign clr_ovr = wr_pulse &
                    (addr2_q == ADDR_STATUS) &
                    wdata2_q[OVR];
   assign ovr_d   = set_ovr | (ovr_q & ~clr_ovr);

   assign cnt_d   = (accept | tick) ? '0
                                    : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         idx_q   <= '0;
         frame_q <= '1;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
         if (accept) begin
            state_q <= ST_SEND;
            tx_q    <= 1'b0;
            idx_q   <= '0;
            frame_q <= frame_build(wdata2_q);
         end else begin
            unique case (state_q)
               ST_IDLE: ;
               ST_SEND: begin
                  if (tick) begin
                     if (last) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                     end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        tx_q    <= frame_q[1];
                        frame_q <= {1'b1,
                           frame_q[FRAME_BITS-1:1]};
                     end
                  end
               end
            endcase
         end
      end
   end

   assign tx        = tx_q;
   assign busy      = (state_q == ST_SEND);
   assign baud_tick = tick;

   // Read path works straight from the pins so the pad driver
   // enable and the data it drives settle together.
   logic                 oe;
   logic [DATA_BITS-1:0] rdata_d;

   assign oe = ~bus.ncs & bus.rw & nrst;

   always_comb begin
      rdata_d = '0;
      if (oe) begin
         unique case (bus.addr)
            ADDR_DATA: begin
               rdata_d[BUSY] = busy;
            end
            ADDR_STATUS: begin
               rdata_d[BUSY] = busy;
               rdata_d[OVR]  = ovr_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.rdata_oe = oe;
   assign bus.rdata    = rdata_d;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomized bench for bus_uart_tx with a timeline model of frames,
// baud phase and overrun; literal frames pin the model.
`timescale 1ns/1ps
module tb_bus_uart_tx;

   localparam int BD = 4;
`ifdef BUS_UART_TX_PARITY_EN
   localparam int NB = 12;
   localparam bit PAR = 1'b1;
   localparam logic [11:0] LIT_A5 = 12'b110101001010;
   localparam logic [11:0] LIT_00 = 12'b110000000000;
   localparam logic [11:0] LIT_07 = 12'b111000001110;
`else
   localparam int NB = 11;
   localparam bit PAR = 1'b0;
   localparam logic [11:0] LIT_A5 = 12'b011101001010;
   localparam logic [11:0] LIT_00 = 12'b011000000000;
`endif
   localparam int FLEN = NB * BD;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic tx;
   logic busy;
   logic baud_tick;

   bus_uart_tx_if bus ();

   bus_uart_tx #(
      .BAUD_DIV (BD)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .bus       (bus),
      .tx        (tx),
      .busy      (busy),
      .baud_tick (baud_tick)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // Model: a write reaching the core at edge e either starts a frame
   // (idle, or exactly at the end of the current one) or sets overrun.
   typedef struct {
      int         e;
      logic [1:0] a;
      logic [7:0] d;
   } wr_ev_t;

   wr_ev_t     evq[$];
   wr_ev_t     m_ev;
   int         edge_n = 0;
   bit         m_have = 1'b0;
   int         m_fs = 0;
   int         m_r = 0;
   logic [7:0] m_data = 8'h00;
   bit         m_ovr = 1'b0;

   function automatic logic exp_bit(input logic [7:0] d,
                                    input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (PAR && i == 9) return ^d;
      return 1'b1;
   endfunction

   function automatic bit m_busy();
      return m_have && (edge_n < m_fs + FLEN);
   endfunction

   function automatic logic [7:0] m_status(input logic [1:0] a);
      case (a)
         2'd0: return {7'b0, m_busy()};
         2'd1: return {6'b0, m_ovr, m_busy()};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         edge_n = 0;
         m_have = 1'b0;
         m_r    = 0;
         m_ovr  = 1'b0;
         evq.delete();
      end else begin
         edge_n++;
         while (evq.size() > 0 && evq[0].e <= edge_n) begin
            m_ev = evq.pop_front();
            if (m_ev.a == 2'd0) begin
               if (m_busy()) begin
                  m_ovr = 1'b1;
               end else begin
                  m_have = 1'b1;
                  m_fs   = edge_n;
                  m_r    = edge_n;
                  m_data = m_ev.d;
               end
            end else if (m_ev.a == 2'd1 && m_ev.d[1]) begin
               m_ovr = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (nrst) begin
         check("busy", 32'(busy), 32'(m_busy()));
         check("tx", 32'(tx), m_busy()
            ? 32'(exp_bit(m_data, (edge_n - m_fs) / BD))
            : 32'd1);
         check("baud_tick", 32'(baud_tick),
               32'(((edge_n - m_r) % BD) == BD - 1));
      end
   end

   bit   cap_en = 1'b0;
   logic txlog[$];
   int   rises = 0;
   logic busy_d = 1'b0;

   always @(negedge clk) begin
      if (cap_en && nrst && busy) txlog.push_back(tx);
      if (!nrst) begin
         busy_d = 1'b0;
      end else begin
         if (busy && !busy_d) rises++;
         busy_d = busy;
      end
   end

   task automatic do_write(input logic [1:0] a,
                           input logic [7:0] d,
                           input int hold);
      wr_ev_t ev;
      @(negedge clk);
      bus.addr  = a;
      bus.wdata = d;
      bus.rw    = 1'b0;
      bus.ncs   = 1'b0;
      ev.e = edge_n + 3;
      ev.a = a;
      ev.d = d;
      evq.push_back(ev);
      repeat (hold) @(negedge clk);
      bus.ncs = 1'b1;
      bus.rw  = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_read(input logic [1:0] a,
                          input string name,
                          input int lit);
      @(negedge clk);
      bus.addr = a;
      bus.rw   = 1'b1;
      bus.ncs  = 1'b0;
      @(negedge clk);
      check({name, "_oe"}, 32'(bus.rdata_oe), 32'd1);
      check(name, 32'(bus.rdata), 32'(m_status(a)));
      if (lit >= 0)
         check({name, "_lit"}, 32'(bus.rdata), 32'(lit));
      bus.ncs = 1'b1;
      #1;
      check({name, "_oe_off"}, 32'(bus.rdata_oe), 32'd0);
      check({name, "_off"}, 32'(bus.rdata), 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic cap_check(input string name,
                            input logic [11:0] lit);
      int k;
      check({name, "_len"}, 32'(txlog.size()), 32'(FLEN));
      for (int i = 0; i < NB; i++) begin
         for (int j = 0; j < BD; j++) begin
            k = i * BD + j;
            if (k < txlog.size())
               check($sformatf("%s_bit%0d", name, i),
                     32'(txlog[k]), 32'(lit[i]));
         end
      end
   endtask

   task automatic cap_start();
      txlog.delete();
      cap_en = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: no finish after 1ms, required finish");
      $fatal(1);
   end

   int r0;
   int tgt;
   int n;
   int op;

   initial begin
      bus.addr  = 2'd0;
      bus.wdata = 8'h00;
      bus.rw    = 1'b1;
      bus.ncs   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(baud_tick), 32'd0);
      check("rst_oe", 32'(bus.rdata_oe), 32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      bus.ncs = 1'b1;
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);

      // Frame, overrun and clear all inside one 0xA5 frame.
      cap_start();
      do_write(2'd0, 8'hA5, 3);
      do_write(2'd0, 8'h3C, 3);
      do_read(2'd1, "stat_ovr", 8'h03);
      do_write(2'd1, 8'h02, 3);
      do_read(2'd1, "stat_clr", 8'h01);
      wait_idle(200);
      cap_en = 1'b0;
      cap_check("frame_a5", LIT_A5);

      // A write held for 100 cycles sends exactly one frame.
      r0 = rises;
      do_write(2'd0, 8'h81, 100);
      wait_idle(200);
      check("held_frames", 32'(rises - r0), 32'd1);

      // A write landing on the edge that ends a frame is taken.
      do_write(2'd0, 8'hC3, 3);
      tgt = m_fs + FLEN - 4;
      n = 0;
      while (edge_n < tgt && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_align", 32'(edge_n), 32'(tgt));
      do_write(2'd0, 8'h96, 3);
      do_read(2'd1, "b2b_stat", 8'h01);
      wait_idle(200);

      // Reset in the middle of a frame.
      do_write(2'd0, 8'h5A, 3);
      repeat (12) @(negedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      nrst = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_tick", 32'(baud_tick), 32'd0);
      @(negedge clk);
      bus.addr = 2'd1;
      bus.rw   = 1'b1;
      bus.ncs  = 1'b0;
      #1;
      check("mid_rst_oe", 32'(bus.rdata_oe), 32'd0);
      check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
      bus.ncs = 1'b1;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      cap_start();
      do_write(2'd0, 8'h00, 3);
      wait_idle(200);
      cap_en = 1'b0;
      cap_check("frame_00", LIT_00);

`ifdef BUS_UART_TX_PARITY_EN
      cap_start();
      do_write(2'd0, 8'h07, 3);
      wait_idle(200);
      cap_en = 1'b0;
      cap_check("frame_07", LIT_07);
`endif

      do_read(2'd2, "rd_a2", 8'h00);
      do_read(2'd3, "rd_a3", 8'h00);
      do_write(2'd2, 8'hFF, 3);
      do_read(2'd0, "rd_a0_idle", 8'h00);

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 9));
         if (op < 5)
            do_write(2'd0, 8'($urandom),
                     3 + int'($urandom_range(0, 2)));
         else if (op < 7)
            do_write(2'd1, 8'($urandom), 3);
         else if (op < 8)
            do_write(2'($urandom_range(2, 3)),
                     8'($urandom), 3);
         else
            do_read(2'($urandom_range(0, 3)), "rnd_read", -1);
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 139, clk cycles per serial bit (minimum 2).
REQ-002 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port: nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: addr  input  2  register address from host bus.
REQ-005 SHALL have port: rw  input  1  1 = read, 0 = write.
REQ-006 SHALL have port: ncs  input  1  chip select, active-low.
REQ-007 SHALL have port: wdata  input  8  host write data; stable while ncs low.
REQ-008 SHALL have port: rdata  output  8  host read data.
REQ-009 SHALL have port: rdata_oe  output  1  tristate enable for external pad buffers.
REQ-010 SHALL have port: tx  output  1  serial line, idle high.
REQ-011 SHALL have port: busy  output  1  frame in progress.
REQ-012 SHALL have port: baud_tick  output  1  one-clk pulse at end of each bit period (debug).

Function
REQ-013 SHALL pass ncs, rw, addr, wdata through a 2-flop synchronizer before use in clk domain.
REQ-014 SHALL form write = !ncs_s & !rw_s and produce a one-cycle write pulse on its rising edge only; a held write never retriggers.
REQ-015 SHALL, on write pulse with addr_s=0 and busy=0, load wdata_s, assert busy and drive tx=0 (start bit) on the next clk edge; latency from first edge sampling the write condition to tx low = 3 clk edges.
REQ-016 SHALL, on write pulse with addr_s=0 and busy=1, drop the data, leave the frame untouched and set sticky overrun.
REQ-017 SHALL send frame: start 0, 8 data bits LSB first, 2 stop bits 1; every bit exactly BAUD_DIV clk cycles.
REQ-018 SHALL restart the baud counter at 0 when a frame is accepted; counter free-runs 0..BAUD_DIV-1 with wrap; baud_tick high when counter = BAUD_DIV-1.
REQ-019 SHALL deassert busy on the edge ending the last stop bit; a new write accepted on that same edge or later.
REQ-020 SHALL decode reads: addr 0 -> {7'b0, busy}; addr 1 -> {6'b0, overrun, busy}; addr 2,3 -> 0x00.
REQ-021 SHALL clear overrun on a write pulse to addr 1 with wdata_s[1]=1; set wins if simultaneous.
REQ-022 SHALL ignore writes to addr 2,3.
REQ-023 SHALL drive rdata_oe = !ncs & rw & nrst combinationally from raw pins; rdata = 0x00 when rdata_oe=0.

Reset
REQ-024 SHALL, while nrst low: tx=1, busy=0, overrun=0, baud counter=0, baud_tick=0, rdata_oe=0, ncs sync flops=1, other sync flops=0.
REQ-025 SHALL abort any frame in progress on reset; tx returns high immediately.

Configuration
REQ-026 SHALL, with BUS_UART_TX_PARITY_EN defined, insert an even-parity bit after data bit 7 (frame 12 bits, busy 12*BAUD_DIV cycles); without it frame is 11 bits and no parity logic exists.

Structure
REQ-027 SHALL place address constants (ADDR_DATA=0, ADDR_STATUS=1), status bit indices (BUSY=0, OVR=1) and frame-length constants in package bus_uart_tx_pkg.
REQ-028 SHALL use one sub-module edge_detect (clk, nrst, in, pulse) for the write-pulse generator.

Verification (BAUD_DIV=4)
REQ-029 SHALL check: write 0xA5 to addr 0 -> tx = 0,1,0,1,0,0,1,0,1,1,1 each held 4 cycles, busy high 44 cycles.
REQ-030 SHALL check: second write 0x3C during frame -> frame unchanged, status read = 0x03; write 0x02 to addr 1 -> status read 0x01.
REQ-031 SHALL check: ncs held low with rw=0 for 100 cycles -> exactly one frame sent.
REQ-032 SHALL check: nrst low at mid-frame -> tx=1, busy=0 same cycle; post-reset write 0x00 sends full frame.
REQ-033 SHALL check: read addr 2 with ncs=0, rw=1 -> rdata_oe=1, rdata=0x00; ncs=1 -> rdata_oe=0.
REQ-034 SHALL check with BUS_UART_TX_PARITY_EN: write 0x07 -> parity bit 1, frame 48 cycles.
